// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register bank: byte-strobed writes, registered reads, SLVERR outside the bank.
// Every register is also exported flat on regs_o for the core logic.
module axi_lite_regfile #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [ADDR_WIDTH-1:0]          aw_addr,
   input  logic                           aw_valid,
   output logic                           aw_ready,
   input  logic [DATA_WIDTH-1:0]          w_data,
   input  logic [DATA_WIDTH/8-1:0]        w_strb,
   input  logic                           w_valid,
   output logic                           w_ready,
   output logic [1:0]                     b_resp,
   output logic                           b_valid,
   input  logic                           b_ready,
   input  logic [ADDR_WIDTH-1:0]          ar_addr,
   input  logic                           ar_valid,
   output logic                           ar_ready,
   output logic [DATA_WIDTH-1:0]          r_data,
   output logic [1:0]                     r_resp,
   output logic                           r_valid,
   input  logic                           r_ready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int LANE_BITS = $clog2(STRB_W);
   localparam int IDX_BITS  = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * STRB_W);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  aw_full;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;

   logic                  commit;
   logic                  aw_in_range;
   logic                  ar_in_range;
   logic [IDX_BITS-1:0]   aw_idx;
   logic [IDX_BITS-1:0]   ar_idx;

   assign aw_ready = aresetn & ~aw_full & ~b_valid;
   assign w_ready  = aresetn & ~w_full & ~b_valid;
   assign ar_ready = aresetn & ~r_valid;

   assign commit      = aw_full & w_full & ~b_valid;
   assign aw_in_range = aw_addr_q < SPAN;
   assign ar_in_range = ar_addr < SPAN;
   assign aw_idx      = aw_addr_q[LANE_BITS +: IDX_BITS];
   assign ar_idx      = ar_addr[LANE_BITS +: IDX_BITS];

   // AW and W are buffered independently; the commit fires once both halves are present.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_full   <= 1'b0;
         aw_addr_q <= '0;
         w_full    <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid   <= 1'b0;
         b_resp    <= RESP_OKAY;
      end else begin
         if (aw_valid && aw_ready) begin
            aw_full   <= 1'b1;
            aw_addr_q <= aw_addr;
         end
         if (w_valid && w_ready) begin
            w_full   <= 1'b1;
            w_data_q <= w_data;
            w_strb_q <= w_strb;
         end
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            b_valid <= 1'b1;
            b_resp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (b_valid && b_ready) begin
            b_valid <= 1'b0;
            b_resp  <= RESP_OKAY;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit && aw_in_range) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs[aw_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
         end
      end
   end

   // Sampling regs here sees the pre-commit value when a write lands on the same edge.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_resp  <= RESP_OKAY;
      end else if (ar_valid && ar_ready) begin
         r_valid <= 1'b1;
         r_data  <= ar_in_range ? regs[ar_idx] : '0;
         r_resp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_valid && r_ready) begin
         r_valid <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
      assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (32-bit data, 8 registers).
module tb_axi_lite_regfile;

   logic        aclk;
   logic        aresetn;
   logic [31:0] aw_addr;
   logic        aw_valid;
   logic        aw_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_valid;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready;
   logic [31:0] ar_addr;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_valid;
   logic        r_ready;
   logic [255:0] regs_o;

   int errors = 0;
   int checks = 0;
   logic [1:0]  last_bresp;
   logic [1:0]  last_rresp;
   logic [31:0] last_rdata;
   logic [31:0] exp_regs [8];

   axi_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .regs_o(regs_o)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), regs_o[i*32 +: 32], exp_regs[i]);
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n;
      aw_addr = addr; aw_valid = 1'b1;
      w_data = data; w_strb = strb; w_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
      n = 0;
      while (!b_valid && n < 10) begin
         step();
         n++;
      end
      chk("wr_b_arrive", b_valid, 1);
      chk("wr_b_latency", n, 1);
      last_bresp = b_resp;
      b_ready = 1'b1;
      step();
      b_ready = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr);
      int n;
      ar_addr = addr; ar_valid = 1'b1;
      step();
      ar_valid = 1'b0;
      n = 0;
      while (!r_valid && n < 10) begin
         step();
         n++;
      end
      chk("rd_r_arrive", r_valid, 1);
      chk("rd_r_latency", n, 0);
      last_rdata = r_data;
      last_rresp = r_resp;
      r_ready = 1'b1;
      step();
      r_ready = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0;
      aw_addr = '0; aw_valid = 1'b0;
      w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b0;
      ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
      for (int i = 0; i < 8; i++) exp_regs[i] = '0;

      // reset state
      #12;
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_regs", regs_o, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      step();
      chk("idle_aw_ready", aw_ready, 1);
      chk("idle_w_ready", w_ready, 1);
      chk("idle_ar_ready", ar_ready, 1);

      // AW and W in the same cycle
      aw_addr = 32'h4; aw_valid = 1'b1;
      w_data = 32'hDEADBEEF; w_strb = 4'hF; w_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
      chk("t1_b_not_yet", b_valid, 0);
      chk("t1_aw_full", aw_ready, 0);
      step();
      chk("t1_b_valid", b_valid, 1);
      chk("t1_b_resp", b_resp, 2'b00);
      chk("t1_reg1", regs_o[63:32], 32'hDEADBEEF);
      b_ready = 1'b1;
      step();
      b_ready = 1'b0;
      chk("t1_b_clear", b_valid, 0);
      exp_regs[1] = 32'hDEADBEEF;
      rd(32'h4);
      chk("t1_rdata", last_rdata, 32'hDEADBEEF);
      chk("t1_rresp", last_rresp, 2'b00);

      // W three cycles ahead of AW
      w_data = 32'h11223344; w_strb = 4'hF; w_valid = 1'b1;
      step();
      w_valid = 1'b0;
      step(); step(); step();
      chk("t2_no_commit", b_valid, 0);
      chk("t2_w_full", w_ready, 0);
      chk("t2_aw_open", aw_ready, 1);
      chk("t2_reg2_old", regs_o[95:64], 0);
      aw_addr = 32'h8; aw_valid = 1'b1;
      step();
      aw_valid = 1'b0;
      chk("t2_b_not_yet", b_valid, 0);
      step();
      chk("t2_b_valid", b_valid, 1);
      chk("t2_b_resp", b_resp, 2'b00);
      chk("t2_reg2", regs_o[95:64], 32'h11223344);
      b_ready = 1'b1;
      step();
      b_ready = 1'b0;
      step(); step();
      chk("t2_single_b", b_valid, 0);
      exp_regs[2] = 32'h11223344;

      // byte strobes
      wr(32'h4, 32'hFFFFFFFF, 4'hF);
      wr(32'h4, 32'h00000000, 4'h5);
      chk("t3_bresp", last_bresp, 2'b00);
      rd(32'h4);
      chk("t3_rdata", last_rdata, 32'hFF00FF00);
      exp_regs[1] = 32'hFF00FF00;
      wr(32'h8, 32'hAAAAAAAA, 4'h0);
      chk("t3_zero_strb_resp", last_bresp, 2'b00);
      chk_regs("t3");

      // range boundaries
      wr(32'h20, 32'h12345678, 4'hF);
      chk("t4_oor_bresp", last_bresp, 2'b10);
      chk_regs("t4_oor");
      wr(32'h1C, 32'hCAFEF00D, 4'hF);
      chk("t4_last_bresp", last_bresp, 2'b00);
      exp_regs[7] = 32'hCAFEF00D;
      rd(32'h1F);
      chk("t4_unaligned_rdata", last_rdata, 32'hCAFEF00D);
      chk("t4_unaligned_rresp", last_rresp, 2'b00);
      rd(32'h40);
      chk("t4_oor_rdata", last_rdata, 0);
      chk("t4_oor_rresp", last_rresp, 2'b10);
      rd(32'h20);
      chk("t4_edge_rresp", last_rresp, 2'b10);

      // read capture and write commit on the same edge, same register
      aw_addr = 32'hC; aw_valid = 1'b1;
      w_data = 32'h55555555; w_strb = 4'hF; w_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
      ar_addr = 32'hC; ar_valid = 1'b1;
      step();
      ar_valid = 1'b0;
      chk("sim_r_valid", r_valid, 1);
      chk("sim_r_old", r_data, 0);
      chk("sim_b_valid", b_valid, 1);
      b_ready = 1'b1; r_ready = 1'b1;
      step();
      b_ready = 1'b0; r_ready = 1'b0;
      exp_regs[3] = 32'h55555555;
      rd(32'hC);
      chk("sim_r_new", last_rdata, 32'h55555555);

      // backpressure on B and R
      aw_addr = 32'h10; aw_valid = 1'b1;
      w_data = 32'h44444444; w_strb = 4'hF; w_valid = 1'b1;
      ar_addr = 32'h1C; ar_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_b_valid", b_valid, 1);
         chk("bp_b_resp", b_resp, 2'b00);
         chk("bp_r_valid", r_valid, 1);
         chk("bp_r_data", r_data, 32'hCAFEF00D);
         chk("bp_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
         step();
      end
      b_ready = 1'b1; r_ready = 1'b1;
      step();
      b_ready = 1'b0; r_ready = 1'b0;
      chk("bp_b_clear", b_valid, 0);
      chk("bp_r_clear", r_valid, 0);
      chk("bp_readies_back", {aw_ready, w_ready, ar_ready}, 3'b111);
      exp_regs[4] = 32'h44444444;
      chk_regs("bp");

      // reset with AW buffered and R pending
      aw_addr = 32'h0; aw_valid = 1'b1;
      ar_addr = 32'h8; ar_valid = 1'b1;
      step();
      aw_valid = 1'b0; ar_valid = 1'b0;
      chk("rm_r_pending", r_valid, 1);
      chk("rm_aw_full", aw_ready, 0);
      #2;
      aresetn = 1'b0;
      #1;
      chk("rm_r_valid", r_valid, 0);
      chk("rm_b_valid", b_valid, 0);
      chk("rm_aw_ready", aw_ready, 0);
      for (int i = 0; i < 8; i++) exp_regs[i] = '0;
      chk_regs("rm");
      @(posedge aclk); #1;
      aresetn = 1'b1;
      step();
      w_data = 32'h00000077; w_strb = 4'hF; w_valid = 1'b1;
      step();
      w_valid = 1'b0;
      step(); step(); step();
      chk("rm_aw_dropped", b_valid, 0);
      chk("rm_aw_open", aw_ready, 1);
      aw_addr = 32'h0; aw_valid = 1'b1;
      step();
      aw_valid = 1'b0;
      step();
      chk("rm_b_valid_after", b_valid, 1);
      chk("rm_b_resp_after", b_resp, 2'b00);
      b_ready = 1'b1;
      step();
      b_ready = 1'b0;
      exp_regs[0] = 32'h00000077;
      chk_regs("rm_after");
      rd(32'h0);
      chk("rm_rdata", last_rdata, 32'h00000077);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
